// File: rtl/bus_txn_sequencer.sv
// Common-bus transaction sequencer: latches granted request, broadcasts snoop, orders WB before memory read.
// Latency: grant -> txn_done in 4 cycles best case (ADDR, SNOOP, MEM with same-cycle ack, DONE).
// Backpressure: stalls in SNOOP on missing snoop_done and in WB/MEM until mem_ack; BUS_SNOOP_TMO_EN bounds SNOOP.
module bus_txn_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int SNOOP_TMO = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          Com_Bus_Gnt_proc,
    input  logic [7:0]          proc_op,
    input  logic [4*ADDR_W-1:0] proc_addr,
    input  logic [3:0]          snoop_done,
    input  logic [3:0]          snoop_hit,
    input  logic [3:0]          snoop_dirty,
    input  logic                mem_ack,
    output logic                bus_valid,
    output logic [1:0]          bus_op,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [1:0]          bus_src,
    output logic [3:0]          snoop_req,
    output logic                mem_wb_req,
    output logic [1:0]          wb_src,
    output logic                mem_rd_req,
    output logic [3:0]          txn_done,
    output logic                shared_out,
    output logic                busy,
    output logic                snoop_err
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SNOOP, S_WB, S_MEM, S_DONE, S_REL} state_t;

    localparam logic [1:0] OP_UPGR = 2'b11;

    state_t              state, state_nxt;
    logic [1:0]          op_q, src_q, wb_src_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          done_mask, hit_mask, dirty_mask;
    logic [3:0]          expected, capture, new_done, new_hit, new_dirty;
    logic [1:0]          gnt_src, gnt_op, dirty_src;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                snoop_complete, tmo_hit;

    // Caches other than the requester; responses from the requester itself are never sampled.
    assign expected       = 4'hF & ~(4'b0001 << src_q);
    assign capture        = snoop_done & expected;
    assign new_done       = done_mask | capture;
    assign new_hit        = hit_mask | (snoop_hit & capture);
    assign new_dirty      = dirty_mask | (snoop_dirty & capture);
    assign snoop_complete = (new_done == expected);

    always_comb begin
        gnt_src = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (Com_Bus_Gnt_proc[i]) gnt_src = 2'(i);
        end
    end

    always_comb begin
        dirty_src = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (new_dirty[i]) dirty_src = 2'(i);
        end
    end

    assign gnt_op   = proc_op[{gnt_src, 1'b0} +: 2];
    assign gnt_addr = proc_addr[32'(gnt_src) * ADDR_W +: ADDR_W];

`ifdef BUS_SNOOP_TMO_EN
    localparam int CNT_W = $clog2(SNOOP_TMO + 1);
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_ADDR) begin
            tmo_cnt <= '0;
        end else if (state == S_SNOOP) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit   = (state == S_SNOOP) && !snoop_complete && (tmo_cnt == CNT_W'(SNOOP_TMO - 1));
    assign snoop_err = tmo_hit;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (SNOOP_TMO > 0);
    assign tmo_hit        = 1'b0;
    assign snoop_err      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|Com_Bus_Gnt_proc) state_nxt = S_ADDR;
            S_ADDR:  state_nxt = S_SNOOP;
            S_SNOOP: begin
                if (snoop_complete || tmo_hit) begin
                    if (op_q == OP_UPGR)  state_nxt = S_DONE;
                    else if (|new_dirty)  state_nxt = S_WB;
                    else                  state_nxt = S_MEM;
                end
            end
            S_WB:    if (mem_ack) state_nxt = S_MEM;
            S_MEM:   if (mem_ack) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_REL;
            // Wait for the requester to release so a held grant cannot relaunch.
            S_REL:   if (!Com_Bus_Gnt_proc[src_q]) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            src_q      <= '0;
            addr_q     <= '0;
            wb_src_q   <= '0;
            done_mask  <= '0;
            hit_mask   <= '0;
            dirty_mask <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && |Com_Bus_Gnt_proc) begin
                src_q  <= gnt_src;
                op_q   <= (gnt_op == 2'b00) ? 2'b01 : gnt_op;
                addr_q <= gnt_addr;
            end
            if (state == S_ADDR) begin
                done_mask  <= '0;
                hit_mask   <= '0;
                dirty_mask <= '0;
            end
            if (state == S_SNOOP) begin
                done_mask  <= new_done;
                hit_mask   <= new_hit;
                dirty_mask <= new_dirty;
                if (state_nxt == S_WB) wb_src_q <= dirty_src;
            end
        end
    end

    assign bus_valid  = (state == S_ADDR);
    assign bus_op     = op_q;
    assign bus_addr   = addr_q;
    assign bus_src    = src_q;
    assign snoop_req  = (state == S_ADDR) ? expected : 4'b0000;
    assign mem_wb_req = (state == S_WB);
    assign wb_src     = wb_src_q;
    assign mem_rd_req = (state == S_MEM);
    assign txn_done   = (state == S_DONE) ? (4'b0001 << src_q) : 4'b0000;
    assign shared_out = (state == S_DONE) && (|hit_mask);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_bus_txn_sequencer.sv
// Self-checking bench for bus_txn_sequencer: vector table, randomized transactions and reset/timeout sequences.
module tb_bus_txn_sequencer;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    Com_Bus_Gnt_proc;
    logic [7:0]    proc_op;
    logic [4*AW-1:0] proc_addr;
    logic [3:0]    snoop_done, snoop_hit, snoop_dirty;
    logic          mem_ack;
    logic          bus_valid, mem_wb_req, mem_rd_req, shared_out, busy, snoop_err;
    logic [1:0]    bus_op, bus_src, wb_src;
    logic [AW-1:0] bus_addr;
    logic [3:0]    snoop_req, txn_done;

    always #5 clk = ~clk;

    bus_txn_sequencer #(.ADDR_W(AW), .SNOOP_TMO(16)) dut (
        .clk(clk), .rst(rst), .Com_Bus_Gnt_proc(Com_Bus_Gnt_proc), .proc_op(proc_op),
        .proc_addr(proc_addr), .snoop_done(snoop_done), .snoop_hit(snoop_hit),
        .snoop_dirty(snoop_dirty), .mem_ack(mem_ack), .bus_valid(bus_valid), .bus_op(bus_op),
        .bus_addr(bus_addr), .bus_src(bus_src), .snoop_req(snoop_req), .mem_wb_req(mem_wb_req),
        .wb_src(wb_src), .mem_rd_req(mem_rd_req), .txn_done(txn_done), .shared_out(shared_out),
        .busy(busy), .snoop_err(snoop_err)
    );

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [3:0]  hit, dirty;
        logic [7:0]  dly;      // per-cache snoop_done delay in SNOOP cycles, 2 bits each
        int          wb_lat, rd_lat, hold;
        logic [1:0]  e_src, e_op, e_wbsrc;
        logic [3:0]  e_snoop;
        logic        e_wb, e_rd, e_shared;
        int          e_lat;    // txn_done cycle index, ADDR cycle = 0
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] all_out();
        return {12'b0, bus_valid, bus_op, bus_addr, bus_src, snoop_req, mem_wb_req, wb_src,
                mem_rd_req, txn_done, shared_out, busy, snoop_err};
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic vec_t mkin(input logic [3:0] gnt, input logic [1:0] op, input logic [31:0] addr,
                                  input logic [3:0] hit, input logic [3:0] dirty, input logic [7:0] dly,
                                  input int wb_lat, input int rd_lat, input int hold);
        vec_t v;
        v = '{default: 0};
        v.gnt = gnt; v.op = op; v.addr = addr; v.hit = hit; v.dirty = dirty; v.dly = dly;
        v.wb_lat = wb_lat; v.rd_lat = rd_lat; v.hold = hold;
        return v;
    endfunction

    // Reference model: outcome of one transaction derived directly from the protocol rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [3:0] others, hits, drt;
        int slen = 0;
        r.e_src   = lowest(v.gnt);
        r.e_op    = (v.op == 2'b00) ? 2'b01 : v.op;
        others    = 4'hF ^ (4'b0001 << r.e_src);
        hits      = v.hit & others;
        drt       = v.dirty & others;
        r.e_snoop = others;
        r.e_rd    = (r.e_op != 2'b11);
        r.e_wb    = r.e_rd && (drt != 0);
        r.e_wbsrc = lowest(drt);
        r.e_shared = (hits != 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] sh = v.dly >> (2 * i);
            if (others[i] && int'(sh[1:0]) + 1 > slen) slen = int'(sh[1:0]) + 1;
        end
        r.e_lat = 1 + slen + (r.e_wb ? v.wb_lat + 1 : 0) + (r.e_rd ? v.rd_lat + 1 : 0);
        return r;
    endfunction

    task automatic load_procs(input logic [1:0] src, input logic [1:0] op, input logic [31:0] addr);
        for (int i = 0; i < 4; i++) begin
            proc_op[2*i +: 2]   = 2'($urandom);
            proc_addr[i*AW +: AW] = $urandom;
        end
        proc_op[2*src +: 2]     = op;
        proc_addr[src*AW +: AW] = addr;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int nvalid = 0, wbc = 0, rdc = 0, ndone = 0, lat = -1, k = 0, after = -1;
        logic [3:0] snp = 0, dval = 0;
        logic [1:0] bop = 0, bsrc = 0, wbs = 0;
        logic [31:0] badr = 0;
        logic shr = 0, busy_addr = 0;
        load_procs(v.e_src, v.op, v.addr);
        @(negedge clk);
        Com_Bus_Gnt_proc = v.gnt;
        snoop_done = 4'b0; snoop_hit = v.hit; snoop_dirty = v.dirty; mem_ack = 1'b0;
        while (k < 150 && !(after >= v.hold + 3)) begin
            @(negedge clk);
            if (bus_valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    snp = snoop_req; bop = bus_op; badr = bus_addr; bsrc = bus_src; busy_addr = busy;
                end
            end
            mem_ack = 1'b0;
            if (mem_wb_req) begin
                wbs = wb_src;
                if (wbc == v.wb_lat) mem_ack = 1'b1;
                wbc++;
            end else if (mem_rd_req) begin
                if (rdc == v.rd_lat) mem_ack = 1'b1;
                rdc++;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            if (txn_done != 4'b0) begin
                ndone++;
                if (ndone == 1) begin dval = txn_done; shr = shared_out; lat = k; after = 0; end
            end else if (after >= 0) begin
                after++;
            end
            if (after == v.hold) Com_Bus_Gnt_proc = 4'b0;
            for (int i = 0; i < 4; i++) begin
                logic [7:0] sh = v.dly >> (2 * i);
                snoop_done[i] = (k >= 1) && (k - 1 >= int'(sh[1:0]));
            end
            k++;
        end
        Com_Bus_Gnt_proc = 4'b0; snoop_done = 4'b0; mem_ack = 1'b0;
        if (lat < 0) chk({tag, " done_timeout"}, 1, 0);
        chk({tag, " bus_valid_count"}, nvalid, 1);
        chk({tag, " snoop_req"}, snp, v.e_snoop);
        chk({tag, " bus_op"}, bop, v.e_op);
        chk({tag, " bus_addr"}, badr, v.addr);
        chk({tag, " bus_src"}, bsrc, v.e_src);
        chk({tag, " busy_in_addr"}, busy_addr, 1);
        chk({tag, " wb_cycles"}, wbc, v.e_wb ? v.wb_lat + 1 : 0);
        if (v.e_wb) chk({tag, " wb_src"}, wbs, v.e_wbsrc);
        chk({tag, " rd_cycles"}, rdc, v.e_rd ? v.rd_lat + 1 : 0);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " txn_done"}, dval, 4'b0001 << v.e_src);
        chk({tag, " shared_out"}, shr, v.e_shared);
        chk({tag, " latency"}, lat, v.e_lat);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        rst = 1'b1; Com_Bus_Gnt_proc = 4'b0; proc_op = '0; proc_addr = '0;
        snoop_done = '0; snoop_hit = '0; snoop_dirty = '0; mem_ack = 1'b0;
        #1 chk("reset_outputs", all_out(), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed table: inputs, then hand-derived expectations.
        v = mkin(4'b0010, 2'b01, 32'h40, 4'b0000, 4'b0000, 8'h00, 0, 2, 1);
        v.e_src = 2'd1; v.e_op = 2'b01; v.e_snoop = 4'b1101; v.e_wb = 0; v.e_wbsrc = 0;
        v.e_rd = 1; v.e_shared = 0; v.e_lat = 5; tbl.push_back(v);
        v = mkin(4'b0001, 2'b01, 32'h1234, 4'b0100, 4'b0100, 8'h00, 1, 0, 0);
        v.e_src = 2'd0; v.e_op = 2'b01; v.e_snoop = 4'b1110; v.e_wb = 1; v.e_wbsrc = 2'd2;
        v.e_rd = 1; v.e_shared = 1; v.e_lat = 5; tbl.push_back(v);
        v = mkin(4'b0100, 2'b11, 32'hABC0, 4'b0010, 4'b0010, 8'h00, 0, 0, 2);
        v.e_src = 2'd2; v.e_op = 2'b11; v.e_snoop = 4'b1011; v.e_wb = 0; v.e_wbsrc = 0;
        v.e_rd = 0; v.e_shared = 1; v.e_lat = 2; tbl.push_back(v);
        v = mkin(4'b1010, 2'b00, 32'hDEAD_BEE0, 4'b1011, 4'b1001, 8'h1E, 0, 1, 1);
        v.e_src = 2'd1; v.e_op = 2'b01; v.e_snoop = 4'b1101; v.e_wb = 1; v.e_wbsrc = 2'd0;
        v.e_rd = 1; v.e_shared = 1; v.e_lat = 7; tbl.push_back(v);
        v = mkin(4'b0010, 2'b10, 32'h80, 4'b0001, 4'b0000, 8'h00, 0, 0, 10);
        v.e_src = 2'd1; v.e_op = 2'b10; v.e_snoop = 4'b1101; v.e_wb = 0; v.e_wbsrc = 0;
        v.e_rd = 1; v.e_shared = 1; v.e_lat = 3; tbl.push_back(v);
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 25; n++) begin
            logic [3:0] h;
            h = 4'($urandom_range(0, 15));
            v = mkin(4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)), $urandom, h,
                     h & 4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            run_vec(model(v), $sformatf("rnd%0d", n));
        end

        // Cache 2 never answers a snoop from proc 3.
        begin
            int errc = 0, err_k = -1, done_k = -1, rdc = 0;
            load_procs(2'd3, 2'b01, 32'h5000);
            @(negedge clk);
            Com_Bus_Gnt_proc = 4'b1000; snoop_done = 4'b0011; snoop_hit = 4'b0; snoop_dirty = 4'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (snoop_err) begin errc++; if (err_k < 0) err_k = k; end
                if (txn_done != 0 && done_k < 0) done_k = k;
                mem_ack = mem_rd_req;
                if (mem_rd_req) rdc++;
                if (done_k >= 0) Com_Bus_Gnt_proc = 4'b0;
            end
`ifdef BUS_SNOOP_TMO_EN
            chk("tmo_err_count", errc, 1);
            chk("tmo_err_cycle", err_k, 16);
            chk("tmo_rd_cycles", rdc, 1);
            chk("tmo_done_cycle", done_k, 18);
`else
            chk("stall_err_count", errc, 0);
            chk("stall_busy", busy, 1);
            chk("stall_rd_cycles", rdc, 0);
            chk("stall_no_done", done_k, -1);
`endif
            Com_Bus_Gnt_proc = 4'b0; snoop_done = 4'b0; mem_ack = 1'b0;
            rst = 1'b1;
            #1 chk("stall_reset_outputs", all_out(), 64'd0);
            @(negedge clk);
            rst = 1'b0;
        end

        // Asynchronous reset while a memory read is outstanding.
        begin
            int k = 0, bad = 0;
            load_procs(2'd0, 2'b01, 32'h9000);
            @(negedge clk);
            Com_Bus_Gnt_proc = 4'b0001; snoop_done = 4'b1111; mem_ack = 1'b0;
            while (k < 20 && !mem_rd_req) begin @(negedge clk); k++; end
            chk("rst_mem_reached", mem_rd_req, 1);
            #2 rst = 1'b1; Com_Bus_Gnt_proc = 4'b0;
            #1 chk("rst_async_outputs", all_out(), 64'd0);
            @(negedge clk);
            rst = 1'b0; mem_ack = 1'b1;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (busy || mem_rd_req || txn_done != 0) bad++;
            end
            mem_ack = 1'b0; snoop_done = 4'b0;
            chk("rst_ack_ignored", bad, 0);
        end

        // Fresh transaction after the reset still sequences normally.
        run_vec(model(mkin(4'b0100, 2'b01, 32'h7777_0000, 4'b1001, 4'b1000, 8'h24, 2, 1, 0)), "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
